// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image over a byte stream, writes it into the
// byte-wide instruction memory from address 0, and releases the CPU reset only after
// a complete image with a matching 8-bit additive checksum has been loaded.
// Frame: SYNC, LEN_HI, LEN_LO, LEN data bytes, CSUM (sum of data bytes mod 256).

module imem_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    // Largest legal image length: the whole memory.
    localparam logic [16:0] CAP = 17'd1 << ADDR_W;

    state_t              state_r;
    state_t              state_s;
    logic [15:0]         count_r;
    logic [15:0]         len_r;
    logic [7:0]          sum_r;
    logic                in_ready_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [7:0]          mem_wdata_r;
    logic                cpu_rst_r;
    logic                done_r;
    logic                err_r;

    logic                accept_s;
    logic                is_sync_s;
    logic [15:0]         len_full_s;
    logic                len_bad_s;

    // Running modulo-256 checksum of the image data bytes.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

    assign accept_s   = in_valid & in_ready_r;
    assign is_sync_s  = (in_data == SYNC_BYTE);
    // Length as it will be once the LEN_LO byte currently on the bus is stored.
    assign len_full_s = {len_r[15:8], in_data};
    // Zero, non-word-multiple or larger-than-memory images are rejected up front.
    assign len_bad_s  = (len_full_s == 16'd0) || (len_full_s[1:0] != 2'b00) ||
                        ({1'b0, len_full_s} > CAP);

    // Next-state decode; the FSM only advances on an accepted byte.
    always_comb begin
        state_s = state_r;
        if (accept_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (is_sync_s) state_s = ST_LEN_HI;
                    else           state_s = ST_IDLE;
                end
                ST_LEN_HI: state_s = ST_LEN_LO;
                ST_LEN_LO: begin
                    if (len_bad_s) state_s = ST_ERROR;
                    else           state_s = ST_DATA;
                end
                ST_DATA: begin
                    if (count_r == (len_r - 16'd1)) state_s = ST_CSUM;
                    else                            state_s = ST_DATA;
                end
                ST_CSUM: begin
                    if (in_data == sum_r) state_s = ST_DONE;
                    else                  state_s = ST_ERROR;
                end
                ST_DONE, ST_ERROR: begin
                    if (is_sync_s) state_s = ST_LEN_HI;
                    else           state_s = state_r;
                end
                default: state_s = ST_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Length/count/checksum capture, imem write port and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            count_r     <= 16'd0;
            len_r       <= 16'd0;
            sum_r       <= 8'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 8'd0;
            cpu_rst_r   <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            in_ready_r <= 1'b1;
            mem_we_r   <= 1'b0;
            if (accept_s) begin
                case (state_r)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (is_sync_s) begin
                            count_r <= 16'd0;
                            len_r   <= 16'd0;
                            sum_r   <= 8'd0;
                        end
                    end
                    ST_LEN_HI: len_r[15:8] <= in_data;
                    ST_LEN_LO: len_r[7:0]  <= in_data;
                    ST_DATA: begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= count_r[ADDR_W-1:0];
                        mem_wdata_r <= in_data;
                        sum_r       <= csum_add(sum_r, in_data);
                        count_r     <= count_r + 16'd1;
                    end
                    default: ;
                endcase
            end
            done_r    <= (state_s == ST_DONE);
            err_r     <= (state_s == ST_ERROR);
            cpu_rst_r <= (state_s != ST_DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_rst   = cpu_rst_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: frames are driven byte by byte, every imem
// write is logged, and logged writes plus status outputs are compared with
// hand-derived expectations.

module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int          checks = 0;
    int          errors = 0;

    logic [7:0]  fr [0:1023];
    logic [9:0]  log_addr [0:4095];
    logic [7:0]  log_data [0:4095];
    int          wr_n = 0;
    int          base;

    imem_loader #(.ADDR_W(10), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Log every imem write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1 && wr_n < 4096) begin
            log_addr[wr_n] = mem_addr;
            log_data[wr_n] = mem_wdata;
            wr_n = wr_n + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        if (gap) idle();
    endtask

    // Send a full frame from fr[0..n-1]; bad is added to the true checksum.
    task automatic send_frame(input int n, input logic [7:0] bad, input bit gap);
        logic [7:0] sum;
        logic [15:0] len;
        len = 16'(n);
        sum = 8'd0;
        send(8'hA5, gap);
        send(len[15:8], gap);
        send(len[7:0], gap);
        for (int i = 0; i < n; i++) begin
            send(fr[i], gap);
            sum = sum + fr[i];
        end
        check_eq("cpu_rst_before_csum", 32'(cpu_rst), 32'd1);
        send(sum + bad, gap);
    endtask

    // Compare the writes logged since first_idx against fr[0..n-1] at addr 0..n-1.
    task automatic check_writes(input int first_idx, input int n);
        check_eq("write_count", 32'(wr_n - first_idx), 32'(n));
        for (int i = 0; i < n; i++) begin
            check_eq("write_addr", 32'(log_addr[first_idx + i]), 32'(i));
            check_eq("write_data", 32'(log_data[first_idx + i]), 32'(fr[i]));
        end
    endtask

    task automatic load_words();
        fr[0] = 8'h00; fr[1] = 8'h00; fr[2] = 8'h00; fr[3] = 8'h13;
        fr[4] = 8'h00; fr[5] = 8'h00; fr[6] = 8'h00; fr[7] = 8'h13;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        idle();
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b0;
        idle();
        check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Test 1: two NOP-like words, checksum 0x26
        load_words();
        base = wr_n;
        send_frame(8, 8'd0, 1'b0);
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_cpu_rst", 32'(cpu_rst), 32'd0);
        check_eq("t1_err", 32'(err), 32'd0);
        idle();
        check_writes(base, 8);

        // Test 2: same frame with wrong checksum 0x27
        base = wr_n;
        send_frame(8, 8'd1, 1'b0);
        check_eq("t2_err", 32'(err), 32'd1);
        check_eq("t2_done", 32'(done), 32'd0);
        check_eq("t2_cpu_rst", 32'(cpu_rst), 32'd1);
        idle();
        check_writes(base, 8);

        // Test 3a: length 6 is not a word multiple
        base = wr_n;
        send(8'hA5, 1'b0); send(8'h00, 1'b0); send(8'h06, 1'b0);
        check_eq("t3_len6_err", 32'(err), 32'd1);
        send(8'h11, 1'b0); send(8'h22, 1'b0);
        idle();
        check_eq("t3_len6_no_write", 32'(wr_n - base), 32'd0);
        // Test 3b: length zero
        send(8'hA5, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        check_eq("t3_len0_err", 32'(err), 32'd1);
        // Test 3c: length 0x401 exceeds capacity
        send(8'hA5, 1'b0);
        check_eq("t3_sync_clears_err", 32'(err), 32'd0);
        send(8'h04, 1'b0); send(8'h01, 1'b0);
        check_eq("t3_len401_err", 32'(err), 32'd1);
        // Test 3d: 0x404 also too long
        send(8'hA5, 1'b0); send(8'h04, 1'b0); send(8'h04, 1'b0);
        check_eq("t3_len404_err", 32'(err), 32'd1);
        idle();
        check_eq("t3_no_write", 32'(wr_n - base), 32'd0);
        // Test 3e: full 1024-byte image
        for (int i = 0; i < 1024; i++) fr[i] = 8'(i * 7 + 3);
        base = wr_n;
        send_frame(1024, 8'd0, 1'b0);
        check_eq("t3_full_done", 32'(done), 32'd1);
        check_eq("t3_full_cpu_rst", 32'(cpu_rst), 32'd0);
        idle();
        check_writes(base, 1024);
        check_eq("t3_last_addr", 32'(log_addr[wr_n - 1]), 32'h3FF);

        // Test 4: in_valid toggled every cycle
        load_words();
        base = wr_n;
        send_frame(8, 8'd0, 1'b1);
        check_eq("t4_done", 32'(done), 32'd1);
        check_eq("t4_cpu_rst", 32'(cpu_rst), 32'd0);
        check_writes(base, 8);

        // Test 5: reset after three data bytes
        base = wr_n;
        send(8'hA5, 1'b0); send(8'h00, 1'b0); send(8'h08, 1'b0);
        send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check_eq("t5_cpu_rst", 32'(cpu_rst), 32'd1);
        check_eq("t5_done", 32'(done), 32'd0);
        send(8'h13, 1'b0); send(8'h00, 1'b0); send(8'h13, 1'b0);
        idle();
        check_eq("t5_writes_stop", 32'(wr_n - base), 32'd3);
        base = wr_n;
        send_frame(8, 8'd0, 1'b0);
        check_eq("t5_reload_done", 32'(done), 32'd1);
        idle();
        check_writes(base, 8);

        // Test 6: junk byte after DONE ignored, SYNC restarts
        send(8'h00, 1'b0);
        check_eq("t6_junk_done", 32'(done), 32'd1);
        check_eq("t6_junk_cpu_rst", 32'(cpu_rst), 32'd0);
        base = wr_n;
        send(8'hA5, 1'b0);
        check_eq("t6_sync_done", 32'(done), 32'd0);
        check_eq("t6_sync_cpu_rst", 32'(cpu_rst), 32'd1);
        send(8'h00, 1'b0); send(8'h08, 1'b0);
        for (int i = 0; i < 8; i++) send(fr[i], 1'b0);
        send(8'h26, 1'b0);
        check_eq("t6_reload_done", 32'(done), 32'd1);
        check_eq("t6_reload_cpu_rst", 32'(cpu_rst), 32'd0);
        idle();
        check_writes(base, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
